mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch port and the data (load/store) port of the pipelined core.
- Sequences each access with a req/ready handshake and holds the bus stable until the memory completes.
- Drives want_stall into the pipeline controller while any requester is still waiting.
- Data accesses have priority; a streak counter stops instruction fetch from being starved.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while inst_req is pending before one fetch is forced; range 1..15.
- TIMEOUT_CYCLES, 64: watchdog limit in cycles. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted when 0
- inst_req  in  1  fetch request; held high with inst_addr stable until inst_ready
- inst_addr  in  32  fetch address, word aligned
- inst_ready  out  1  one-cycle completion pulse for fetch
- inst_rdata  out  32  fetched word; valid only when inst_ready=1
- data_req  in  1  data request; held high with all data_* stable until data_ready
- data_we  in  1  1 = store, 0 = load
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_be  in  4  byte enables for stores
- data_ready  out  1  one-cycle completion pulse for data
- data_rdata  out  32  load data; valid only when data_ready=1
- mem_valid  out  1  bus request; held until mem_ready
- mem_we  out  1  bus write strobe
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_be  out  4  bus byte enables; 4'hF for fetches
- mem_ready  in  1  memory completion; sampled only while mem_valid=1
- mem_rdata  in  32  memory read data, valid with mem_ready
- want_stall  out  1  equals (inst_req & ~inst_ready) | (data_req & ~data_ready)
- bus_error  out  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE, streak=0, bus_error=0. Outputs mem_valid, mem_we, inst_ready and data_ready are 0; mem_addr, mem_wdata and mem_be are 0.
- FSM states: IDLE, GRANT_INST, GRANT_DATA.
- IDLE transitions, registered:
  - data_req=1 and (streak<MAX_DATA_STREAK or inst_req=0): go to GRANT_DATA.
  - Otherwise, inst_req=1: go to GRANT_INST.
  - Neither request: stay in IDLE.
- On entering GRANT_*:
  - Latch the selected port's address, write data, byte enables and we into bus registers.
  - Drive mem_valid=1 from the next cycle.
  - Latency: request in cycle N gives mem_valid in cycle N+1.
- In GRANT_*, while mem_valid=1 and mem_ready=1:
  - Same cycle: the owner's ready=1 and rdata=mem_rdata (combinational pass-through).
  - Next cycle: mem_valid=0 and state returns to IDLE.
- Minimum access time is 2 cycles with a zero-wait memory. No back-to-back grants; IDLE always intervenes.
- Streak counter:
  - Increments when GRANT_DATA is entered while inst_req=1.
  - Clears to 0 when GRANT_INST is entered, or when data is granted with inst_req=0.
  - Saturates at MAX_DATA_STREAK.
- Simultaneous inst_req and data_req in IDLE: data wins unless streak==MAX_DATA_STREAK.
- A requester dropping req before its ready pulse is a protocol violation; the in-flight bus access still completes and the ready pulse is still issued.
- Reset asserted mid-access: state drops to IDLE and mem_valid falls immediately (asynchronous). No ready pulse is issued; the memory side must tolerate the abandoned access.
- The non-owner port's ready stays 0 throughout.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in GRANT_* while mem_ready=0.
  - On reaching TIMEOUT_CYCLES: pulse the owner's ready with rdata=32'h0, set bus_error=1 (sticky until reset) and return to IDLE.
- Undefined: no counter exists; bus_error is tied to 0 and the arbiter waits indefinitely for mem_ready.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_t enum (IDLE, GRANT_INST, GRANT_DATA).
  - Constant MEM_BE_WORD=4'hF.
  - Streak counter width, derived from MAX_DATA_STREAK.
- One sub-module, mem_arb_watchdog: the timeout counter with clear, enable and expire pins, instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0x100, memory with 2 wait states returning 0x00000013 -> mem_valid rises at N+1, inst_ready pulses at N+3 with inst_rdata=0x13, want_stall=1 for cycles N..N+2.
- Simultaneous requests: inst_req=1 and data_req=1 (store to 0x2000, data 0xDEADBEEF, be=4'b0011), zero-wait memory -> data granted first with mem_we=1 and mem_be=4'b0011; fetch granted afterwards.
- Starvation: data_req held with a new access after every ready, inst_req held, MAX_DATA_STREAK=4 -> exactly 4 data grants, then 1 inst grant, then data again.
- Reset mid-access: reset=0 while mem_valid=1 -> mem_valid=0 in the same cycle, no ready pulse, state IDLE after release.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_ready never asserted on a load -> data_ready pulses with data_rdata=0 after 8 waiting cycles, bus_error=1 and stays 1.
- Idle bus: no requests for 20 cycles -> mem_valid=0, want_stall=0, streak=0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter bus ownership states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } arb_state_t;

  // Byte enables driven for instruction fetches.
  localparam logic [3:0] MEM_BE_WORD = 4'hF;

  // Largest supported MAX_DATA_STREAK value.
  localparam int unsigned MAX_STREAK_LIMIT = 15;

  // One latched bus access, held stable while mem_valid is high.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  // Width of a streak counter able to hold 0..max_streak.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory bus signals.
// slave  : the arbiter's view (serves the core ports, masters the memory bus).
// master : the environment's view (core ports drive requests, memory responds).
interface mem_port_arbiter_if;

  // Instruction-fetch port.
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_rdata;

  // Data (load/store) port.
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_ready;
  logic [31:0] data_rdata;

  // Shared memory bus.
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_ready, inst_rdata,
    input  data_req, data_we, data_addr, data_wdata, data_be,
    output data_ready, data_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_ready, inst_rdata,
    output data_req, data_we, data_addr, data_wdata, data_be,
    input  data_ready, data_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Bus access watchdog: counts waiting cycles of an in-flight access and
// flags expiry once TIMEOUT_CYCLES of them have elapsed. Only instantiated
// when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic clear_i,   // no access in flight
  input  logic enable_i,  // access in flight and memory not ready this cycle
  output logic expire_o   // this is the TIMEOUT_CYCLES-th waiting cycle
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expire_o = enable_i && (count_q == LAST_WAIT);

  // Next count: restart between accesses, advance on every waiting cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Waiting-cycle counter register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory bus between instruction fetch and
// data accesses. Data has priority; a streak counter forces one fetch after
// MAX_DATA_STREAK consecutive data grants made while a fetch was waiting.
// Every access passes through IDLE, so the minimum access time is 2 cycles.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that
// completes a stuck access after TIMEOUT_CYCLES waiting cycles with zero
// read data and raises the sticky bus_error_o flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES  = 64
`endif
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  mem_port_arbiter_if.slave   bus,
  output logic                want_stall_o,
  output logic                bus_error_o
);

  localparam int unsigned STREAK_W = streak_width(MAX_DATA_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  bus_req_t            bus_q, bus_d;
  logic                timeout_expire;
  logic                data_win;
  logic                in_grant;

  // Data wins unless a waiting fetch has already been passed over too often.
  assign data_win = bus.data_req && ((streak_q < STREAK_MAX) || !bus.inst_req);
  assign in_grant = (state_q != IDLE);

  // Next-state, streak and bus-latch decisions.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    streak_d = streak_q;
    bus_d    = bus_q;
    unique case (state_q)
      IDLE: begin
        if (data_win) begin
          state_d = GRANT_DATA;
          bus_d   = '{we: bus.data_we, addr: bus.data_addr,
                      wdata: bus.data_wdata, be: bus.data_be};
          if (!bus.inst_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (bus.inst_req) begin
          state_d  = GRANT_INST;
          bus_d    = '{we: 1'b0, addr: bus.inst_addr,
                       wdata: 32'h0, be: MEM_BE_WORD};
          streak_d = '0;
        end
      end
      GRANT_INST, GRANT_DATA: begin
        if (bus.mem_ready || timeout_expire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, streak counter and latched bus access registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    // NOTE: the bus registers are reset along with the state so mem_addr,
    // mem_wdata and mem_be read as zero after reset rather than X.
    if (!reset_ni) begin
      state_q  <= IDLE;
      streak_q <= '0;
      bus_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      streak_q <= streak_d;
      bus_q    <= bus_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic bus_error_q;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .clear_i  (!in_grant),
    .enable_i (in_grant && !bus.mem_ready),
    .expire_o (timeout_expire)
  );

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bus_error_q <= 1'b0;
    end else if (timeout_expire) begin
      bus_error_q <= 1'b1;
    end
  end

  assign bus_error_o = bus_error_q;
`else
  assign timeout_expire = 1'b0;
  assign bus_error_o    = 1'b0;
`endif

  // Memory bus: valid for the whole time an access is owned.
  assign bus.mem_valid = in_grant;
  assign bus.mem_we    = bus_q.we;
  assign bus.mem_addr  = bus_q.addr;
  assign bus.mem_wdata = bus_q.wdata;
  assign bus.mem_be    = bus_q.be;

  // Completion pulses and read data pass straight through to the owner only.
  assign bus.inst_ready = (state_q == GRANT_INST) && (bus.mem_ready || timeout_expire);
  assign bus.data_ready = (state_q == GRANT_DATA) && (bus.mem_ready || timeout_expire);
  assign bus.inst_rdata = ((state_q == GRANT_INST) && bus.mem_ready) ? bus.mem_rdata : 32'h0;
  assign bus.data_rdata = ((state_q == GRANT_DATA) && bus.mem_ready) ? bus.mem_rdata : 32'h0;

  assign want_stall_o = (bus.inst_req && !bus.inst_ready) ||
                        (bus.data_req && !bus.data_ready);

endmodule
